// File: rtl/imm_gen_pipe.sv
// RV32 immediate decoder feeding a 2-entry FIFO of {imm, fmt, illegal}.
// Decoding happens at push time. Outputs are taken from the registered head and are zero while empty.
module imm_gen_pipe #(
    parameter int unsigned XLEN     = 32,
    parameter bit          SIGN_EXT = 1'b1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic             in_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    logic [6:0]      opcode;
    logic            fill;
    fmt_e            fmt_dec;
    logic            illegal_dec;
    logic [31:0]     raw;
    logic [XLEN-1:0] imm_ext;
    entry_t          entry_new;

    logic [1:0]      count;
    logic            wr_ptr;
    logic            rd_ptr;
    entry_t          mem [2];
    entry_t          head;
    logic            push;
    logic            pop;

    // Decode: format selection, then the raw immediate already extended to 32 bits.
    always_comb begin
        opcode      = in_instr[6:0];
        fill        = SIGN_EXT ? in_instr[31] : 1'b0;
        fmt_dec     = FMT_NONE;
        illegal_dec = 1'b0;
        case (opcode)
            7'b0110011, 7'b0001011:            fmt_dec = FMT_NONE;
            7'b0010011, 7'b0000011, 7'b1100111: fmt_dec = FMT_I;
            7'b0100011:                        fmt_dec = FMT_S;
            7'b1100011:                        fmt_dec = FMT_B;
            7'b0110111, 7'b0010111:            fmt_dec = FMT_U;
            7'b1101111:                        fmt_dec = FMT_J;
            default:                           illegal_dec = 1'b1;
        endcase
        if (!in_en) begin
            fmt_dec     = FMT_NONE;
            illegal_dec = 1'b0;
        end
        raw = '0;
        case (fmt_dec)
            FMT_I:   raw = {{20{fill}}, in_instr[31:20]};
            FMT_S:   raw = {{20{fill}}, in_instr[31:25], in_instr[11:7]};
            FMT_B:   raw = {{19{fill}}, in_instr[31], in_instr[7], in_instr[30:25],
                            in_instr[11:8], 1'b0};
            FMT_U:   raw = {in_instr[31:12], 12'b0};
            FMT_J:   raw = {{11{fill}}, in_instr[31], in_instr[19:12], in_instr[20],
                            in_instr[30:21], 1'b0};
            default: raw = '0;
        endcase
    end

    // Upper-word extension applies to every real format, U included; none/illegal stay zero.
    generate
        if (XLEN == 64) begin : g_xlen64
            logic upper_fill;
            assign upper_fill = fill & (fmt_dec != FMT_NONE);
            assign imm_ext    = {{(XLEN-32){upper_fill}}, raw};
        end else begin : g_xlen32
            assign imm_ext = raw;
        end
    endgenerate

    always_comb begin
        entry_new.imm     = imm_ext;
        entry_new.fmt     = fmt_dec;
        entry_new.illegal = illegal_dec;
    end

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            mem[0]  <= '0;
            mem[1]  <= '0;
            err_cnt <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= entry_new;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (push && entry_new.illegal && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        head        = mem[rd_ptr];
        out_imm     = '0;
        out_fmt     = '0;
        out_illegal = 1'b0;
        if (out_valid) begin
            out_imm     = head.imm;
            out_fmt     = head.fmt;
            out_illegal = head.illegal;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: three instances (32/sign, 64/sign with a 4-bit counter,
// 64/zero) share one stimulus stream; expected values are hand-computed constants.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_en;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_imm;
    logic [2:0]  a_out_fmt;
    logic [15:0] a_err_cnt;

    logic        w_in_ready, w_out_valid, w_out_illegal;
    logic [63:0] w_out_imm;
    logic [2:0]  w_out_fmt;
    logic [3:0]  w_err_cnt;

    logic        z_in_ready, z_out_valid, z_out_illegal;
    logic [63:0] z_out_imm;
    logic [2:0]  z_out_fmt;
    logic [15:0] z_err_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    imm_gen_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_en(in_en), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_illegal(a_out_illegal),
        .err_cnt(a_err_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .SIGN_EXT(1'b1), .CNT_W(4)) dut64s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_instr(in_instr), .in_en(in_en), .out_valid(w_out_valid), .out_ready(out_ready),
        .out_imm(w_out_imm), .out_fmt(w_out_fmt), .out_illegal(w_out_illegal),
        .err_cnt(w_err_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .SIGN_EXT(1'b0), .CNT_W(16)) dut64z (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(z_in_ready),
        .in_instr(in_instr), .in_en(in_en), .out_valid(z_out_valid), .out_ready(out_ready),
        .out_imm(z_out_imm), .out_fmt(z_out_fmt), .out_illegal(z_out_illegal),
        .err_cnt(z_err_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Push one word with out_ready=1, check the head one cycle later, then let it pop.
    task automatic push_one(input string tag, input logic [31:0] word, input logic en,
                            input logic [31:0] e32, input logic [63:0] e64s,
                            input logic [63:0] e64z, input logic [2:0] efmt,
                            input logic eill);
        in_valid = 1'b1;
        in_instr = word;
        in_en    = en;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, " valid"},   {63'd0, a_out_valid}, 64'd1);
        check({tag, " imm32"},   {32'd0, a_out_imm}, {32'd0, e32});
        check({tag, " imm64s"},  w_out_imm, e64s);
        check({tag, " imm64z"},  z_out_imm, e64z);
        check({tag, " fmt"},     {61'd0, a_out_fmt}, {61'd0, efmt});
        check({tag, " fmt64z"},  {61'd0, z_out_fmt}, {61'd0, efmt});
        check({tag, " illegal"}, {63'd0, a_out_illegal}, {63'd0, eill});
        @(posedge clk); #1;
        check({tag, " drained"}, {63'd0, a_out_valid}, 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_en     = 1'b1;
        out_ready = 1'b1;
        #2;
        check("rst in_ready",  {63'd0, a_in_ready}, 64'd1);
        check("rst out_valid", {63'd0, a_out_valid}, 64'd0);
        check("rst out_imm",   {32'd0, a_out_imm}, 64'd0);
        check("rst out_fmt",   {61'd0, a_out_fmt}, 64'd0);
        check("rst illegal",   {63'd0, a_out_illegal}, 64'd0);
        check("rst err_cnt",   {48'd0, a_err_cnt}, 64'd0);
        #5 rst_n = 1'b1;

        // First push lands on the first rising edge after reset release.
        push_one("addi",  32'hFFF00093, 1'b1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                 64'h0000000000000FFF, 3'd1, 1'b0);
        push_one("sw",    32'hFE20AE23, 1'b1, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC,
                 64'h0000000000000FFC, 3'd2, 1'b0);
        push_one("beq",   32'hFE000CE3, 1'b1, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8,
                 64'h0000000000001FF8, 3'd3, 1'b0);
        push_one("lui",   32'h123452B7, 1'b1, 32'h12345000, 64'h0000000012345000,
                 64'h0000000012345000, 3'd4, 1'b0);
        push_one("jal",   32'h001000EF, 1'b1, 32'h00000800, 64'h0000000000000800,
                 64'h0000000000000800, 3'd5, 1'b0);
        push_one("luineg", 32'h800000B7, 1'b1, 32'h80000000, 64'hFFFFFFFF80000000,
                 64'h0000000080000000, 3'd4, 1'b0);
        push_one("add",   32'h00B50533, 1'b1, 32'h0, 64'h0, 64'h0, 3'd0, 1'b0);
        push_one("custom0", 32'hFFF0000B, 1'b1, 32'h0, 64'h0, 64'h0, 3'd0, 1'b0);
        push_one("addi_en0", 32'hFFF00093, 1'b0, 32'h0, 64'h0, 64'h0, 3'd0, 1'b0);
        check("err_cnt none", {48'd0, a_err_cnt}, 64'd0);

        push_one("illegal", 32'h0000007F, 1'b1, 32'h0, 64'h0, 64'h0, 3'd0, 1'b1);
        check("err_cnt one",   {48'd0, a_err_cnt}, 64'd1);
        check("err_cnt one w", {60'd0, w_err_cnt}, 64'd1);
        for (int i = 0; i < 15; i++) begin
            push_one("illegal_n", 32'hFFFFFFFF, 1'b1, 32'h0, 64'h0, 64'h0, 3'd0, 1'b1);
        end
        check("err_cnt 16",     {48'd0, a_err_cnt}, 64'd16);
        check("err_cnt sat w",  {60'd0, w_err_cnt}, 64'd15);
        push_one("illegal_sat", 32'h0000007F, 1'b1, 32'h0, 64'h0, 64'h0, 3'd0, 1'b1);
        check("err_cnt 17",     {48'd0, a_err_cnt}, 64'd17);
        check("err_cnt hold w", {60'd0, w_err_cnt}, 64'd15);
        check("err_cnt 17 z",   {48'd0, z_err_cnt}, 64'd17);
        push_one("illegal_en0", 32'h0000007F, 1'b0, 32'h0, 64'h0, 64'h0, 3'd0, 1'b0);
        check("err_cnt en0",    {48'd0, a_err_cnt}, 64'd17);

        // Backpressure: A, B fill the FIFO, C is held off until a slot frees.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_en     = 1'b1;
        in_instr  = 32'hFFF00093;
        @(posedge clk); #1;
        check("bp A ready", {63'd0, a_in_ready}, 64'd1);
        check("bp A head",  {32'd0, a_out_imm}, 64'hFFFFFFFF);
        in_instr = 32'h123452B7;
        @(posedge clk); #1;
        check("bp full ready", {63'd0, a_in_ready}, 64'd0);
        check("bp full head",  {32'd0, a_out_imm}, 64'hFFFFFFFF);
        in_instr = 32'h001000EF;
        @(posedge clk); #1;
        check("bp hold ready", {63'd0, a_in_ready}, 64'd0);
        check("bp hold head",  {61'd0, a_out_fmt}, 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp pop A ready", {63'd0, a_in_ready}, 64'd1);
        check("bp B head",      {32'd0, a_out_imm}, 64'h12345000);
        check("bp B fmt",       {61'd0, a_out_fmt}, 64'd4);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp C head",  {32'd0, a_out_imm}, 64'h00000800);
        check("bp C fmt",   {61'd0, a_out_fmt}, 64'd5);
        check("bp C valid", {63'd0, a_out_valid}, 64'd1);
        @(posedge clk); #1;
        check("bp empty", {63'd0, a_out_valid}, 64'd0);

        // Reset mid-operation with the FIFO full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h0000007F;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid full ready", {63'd0, a_in_ready}, 64'd0);
        check("mid err_cnt",    {48'd0, a_err_cnt}, 64'd19);
        #1 rst_n = 1'b0;
        #1;
        check("mid rst valid",   {63'd0, a_out_valid}, 64'd0);
        check("mid rst ready",   {63'd0, a_in_ready}, 64'd1);
        check("mid rst err_cnt", {48'd0, a_err_cnt}, 64'd0);
        check("mid rst illegal", {63'd0, a_out_illegal}, 64'd0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post rst valid", {63'd0, a_out_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
